// File: rtl/alu_chain_pkg.sv
// Shared ALU types for the nibble-serial chain wrapper.
// Op encoding matches the CPU ALU.
package alu_chain_pkg;

  typedef enum logic [3:0] {
    ALU_ADD        = 4'd0,
    ALU_ADC        = 4'd1,
    ALU_ADC_NO_DEC = 4'd2,
    ALU_SUB        = 4'd3,
    ALU_SBC        = 4'd4,
    ALU_AND        = 4'd5,
    ALU_OR         = 4'd6,
    ALU_XOR        = 4'd7,
    ALU_RLC        = 4'd8,
    ALU_RRC        = 4'd9,
    ALU_CP         = 4'd10,
    ALU_NOT        = 4'd11
  } alu_op_t;

  localparam int ALU_CHAIN_MAX_NIBBLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chain_state_t;

  function automatic logic is_msb_first(input alu_op_t op);
    return op == ALU_RRC;
  endfunction

  // ADD, SUB and CP start their chain from a clear carry
  function automatic logic uses_carry_in(input alu_op_t op);
    return !(op == ALU_ADD || op == ALU_SUB || op == ALU_CP);
  endfunction

endpackage

// File: rtl/alu_chain_nibble.sv
// Per-nibble ALU core: one 4-bit slice with carry/borrow
// in and out, binary or BCD.
module alu_chain_nibble
  import alu_chain_pkg::*;
(
  input  alu_op_t    op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       decimal,
  output logic [3:0] r,
  output logic       c_out,
  output logic       illegal
);

  logic [4:0] sum;
  logic [4:0] dif;
  logic       dec_add;
  logic       dec_sub;

  assign sum = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
  assign dif = {1'b0, a} - {1'b0, b} - {4'b0, c_in};

  assign dec_add = decimal && (op != ALU_ADC_NO_DEC);
  assign dec_sub = decimal && (op != ALU_CP);

  always_comb begin
    r       = a;
    c_out   = c_in;
    illegal = 1'b0;
    unique case (op)
      ALU_ADD, ALU_ADC, ALU_ADC_NO_DEC: begin
        r     = sum[3:0];
        c_out = sum[4];
        if (dec_add && sum >= 5'd10) begin
          r     = sum[3:0] - 4'd10;
          c_out = 1'b1;
        end
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        // dif[4] is the borrow: a-b-c never drops below -16
        r     = dif[3:0];
        c_out = dif[4];
        if (dec_sub && dif[4]) begin
          r = dif[3:0] + 4'd10;
        end
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_RLC: begin
        r     = {a[2:0], c_in};
        c_out = a[3];
      end
      ALU_RRC: begin
        r     = {c_in, a[3:1]};
        c_out = a[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_chain.sv
// Runs one ALU op across NIBBLES digits, one nibble per
// clock, chaining carry/borrow through a single core.
module alu_chain
  import alu_chain_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  alu_op_t              op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 carry_in,
  input  logic                 decimal_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 zero_out,
  output logic                 illegal
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(ALU_CHAIN_MAX_NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  function automatic logic [W-1:0] rotr4(input logic [W-1:0] x);
    return (x >> 4) | (x << (W - 4));
  endfunction

  function automatic logic [W-1:0] rotl4(input logic [W-1:0] x);
    return (x << 4) | (x >> (W - 4));
  endfunction

  chain_state_t   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  alu_op_t        op_q, op_d;
  logic           dec_q, dec_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           c_q, c_d;
  logic           zacc_q, zacc_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;
  logic           zero_out_q, zero_out_d;
  logic           illegal_q, illegal_d;

  logic           msb;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [3:0]     nib_r;
  logic           nib_c;
  logic           nib_ill;
  logic [W-1:0]   nib_ext;

  assign msb     = is_msb_first(op_q);
  assign nib_a   = msb ? a_q[W-1 -: 4] : a_q[3:0];
  assign nib_b   = msb ? b_q[W-1 -: 4] : b_q[3:0];
  assign nib_ext = W'(nib_r);

  alu_chain_nibble u_core (
    .op      (op_q),
    .a       (nib_a),
    .b       (nib_b),
    .c_in    (c_q),
    .decimal (dec_q),
    .r       (nib_r),
    .c_out   (nib_c),
    .illegal (nib_ill)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    dec_d       = dec_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    c_d         = c_q;
    zacc_d      = zacc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_out_d  = zero_out_q;
    illegal_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          op_d    = op;
          dec_d   = decimal_in;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          c_d     = uses_carry_in(op) ? carry_in : 1'b0;
          zacc_d  = 1'b1;
        end
      end
      RUN: begin
        idx_d  = idx_q + 1'b1;
        c_d    = nib_c;
        zacc_d = zacc_q & (nib_r == 4'd0);
        // A rotates a full turn so it is intact for CP
        if (msb) begin
          a_d   = rotl4(a_q);
          b_d   = rotl4(b_q);
          acc_d = (acc_q << 4) | nib_ext;
        end else begin
          a_d   = rotr4(a_q);
          b_d   = rotr4(b_q);
          acc_d = (acc_q >> 4) | (nib_ext << (W - 4));
        end
        if (idx_q == LAST) begin
          state_d     = DONE;
          carry_out_d = nib_c;
          zero_out_d  = zacc_d;
          illegal_d   = nib_ill;
          result_d    = (op_q == ALU_CP) ? a_d : acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op_q        <= ALU_ADD;
      dec_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      zacc_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_out_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      dec_q       <= dec_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      zacc_q      <= zacc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_out_q  <= zero_out_d;
      illegal_q   <= illegal_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero_out  = zero_out_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_chain.sv
// Directed bench for alu_chain with NIBBLES=4.
// Hand-computed vectors, immediate assertions.
module tb_alu_chain;
  import alu_chain_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  alu_op_t      op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         decimal_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero_out;
  logic         illegal;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int busyc;
  int dones;

  alu_chain #(.NIBBLES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .decimal_in (decimal_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .zero_out   (zero_out),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat counts edges from the start-sampling edge through
  // the edge after which done is seen
  task automatic wait_done();
    while (!done && lat < 20) begin
      if (busy) busyc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input alu_op_t o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ci,
                        input logic dc);
    @(negedge clk);
    op = o; a = aa; b = bb; carry_in = ci; decimal_in = dc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    busyc = 0;
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = ALU_ADD;
    a = '0; b = '0; carry_in = 1'b0; decimal_in = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {29'd0, carry_out, zero_out, illegal}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(ALU_ADD, 16'h0FFF, 16'h0001, 1'b1, 1'b0);
    chk("add_lat", 32'(lat), 5);
    chk("add_busy", 32'(busyc), 4);
    chk("add_res", 32'(result), 32'h1000);
    chk("add_cz", {30'd0, carry_out, zero_out}, 0);
    chk("add_ill", 32'(illegal), 0);

    run_op(ALU_ADC, 16'h0999, 16'h0001, 1'b1, 1'b1);
    chk("adcd1_res", 32'(result), 32'h1001);
    chk("adcd1_c", 32'(carry_out), 0);

    run_op(ALU_ADC, 16'h9999, 16'h0001, 1'b0, 1'b1);
    chk("adcd2_res", 32'(result), 32'h0000);
    chk("adcd2_cz", {30'd0, carry_out, zero_out}, 32'b11);

    run_op(ALU_SBC, 16'h0000, 16'h0001, 1'b0, 1'b1);
    chk("sbcd_res", 32'(result), 32'h9999);
    chk("sbcd_c", 32'(carry_out), 1);

    run_op(ALU_SUB, 16'h1000, 16'h0001, 1'b1, 1'b0);
    chk("sub_res", 32'(result), 32'h0FFF);
    chk("sub_c", 32'(carry_out), 0);

    run_op(ALU_ADC_NO_DEC, 16'h0999, 16'h0001, 1'b0, 1'b1);
    chk("nodec_res", 32'(result), 32'h099A);

    run_op(ALU_RLC, 16'h8001, 16'h0000, 1'b1, 1'b0);
    chk("rlc_res", 32'(result), 32'h0003);
    chk("rlc_c", 32'(carry_out), 1);

    run_op(ALU_RRC, 16'h0001, 16'h0000, 1'b0, 1'b0);
    chk("rrc_res", 32'(result), 32'h0000);
    chk("rrc_cz", {30'd0, carry_out, zero_out}, 32'b11);

    run_op(ALU_CP, 16'h1234, 16'h1234, 1'b1, 1'b1);
    chk("cpeq_res", 32'(result), 32'h1234);
    chk("cpeq_cz", {30'd0, carry_out, zero_out}, 32'b01);

    run_op(ALU_CP, 16'h1233, 16'h1234, 1'b0, 1'b0);
    chk("cplt_res", 32'(result), 32'h1233);
    chk("cplt_cz", {30'd0, carry_out, zero_out}, 32'b10);

    run_op(ALU_AND, 16'hF0F0, 16'hFF00, 1'b1, 1'b0);
    chk("and_res", 32'(result), 32'hF000);
    chk("and_c", 32'(carry_out), 1);

    run_op(ALU_NOT, 16'h5A5A, 16'h0000, 1'b1, 1'b0);
    chk("not_lat", 32'(lat), 5);
    chk("not_ill", 32'(illegal), 1);
    chk("not_res", 32'(result), 32'h5A5A);
    chk("not_c", 32'(carry_out), 1);
    @(posedge clk);
    #1;
    chk("not_idle", {30'd0, done, illegal}, 0);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    op = ALU_ADD; a = 16'h0001; b = 16'h0001;
    carry_in = 1'b0; decimal_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; lat = 1; busyc = 0;
    @(posedge clk);
    #1;
    lat++;
    @(negedge clk);
    op = ALU_XOR; a = 16'hFFFF; b = 16'h1234; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat++;
    wait_done();
    chk("ign_lat", 32'(lat), 5);
    chk("ign_res", 32'(result), 32'h0002);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    chk("ign_noextra", 32'(dones), 0);

    // reset two cycles into RUN
    @(negedge clk);
    op = ALU_ADD; a = 16'h0FFF; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rrun_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rrun_busy0", 32'(busy), 0);
    chk("rrun_done0", 32'(done), 0);
    chk("rrun_res0", 32'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    chk("rrun_nodone", 32'(dones), 0);

    run_op(ALU_ADD, 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    chk("post_lat", 32'(lat), 5);
    chk("post_res", 32'(result), 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
